// File: rtl/scale_window_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// scale_window_ctrl_pkg
// Shared types and widths for the scaled-window timing/addressing engine
// that sits between the HDMI timing core and the GBA line cache.
//   lock_state_t  : frame-lock FSM states (FREE / REQ / LOCKED)
//   SCALE_CNT_W   : width of the per-axis sub-pixel / sub-line counters
//   SRC_IDX_W     : width of the source pixel / line indices
//   CX_W / CY_W   : widths of the HDMI horizontal / vertical counters
//   window_start(): centring offset of a scaled axis inside the frame
// ---------------------------------------------------------------------------
package scale_window_ctrl_pkg;

    localparam int SCALE_CNT_W = 3;
    localparam int SRC_IDX_W   = 8;
    localparam int CX_W        = 12;
    localparam int CY_W        = 11;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        REQ    = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // Offset that centres an axis of src_len pixels scaled by 'scale'.
    function automatic int window_start(input int frame_len, input int scale, input int src_len);
        return (frame_len - scale * src_len) / 2;
    endfunction

endpackage

// File: rtl/scale_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// scale_window_ctrl_if
// Bundles the HDMI-side timing inputs and the cache/pixel-mux side outputs of
// scale_window_ctrl.
//   master : the surrounding system (drives cx/cy/frame sizes/newFrameIn/
//            sameLine, consumes the window, index and handshake outputs)
//   slave  : scale_window_ctrl itself
// Optional: gridAct exists only when SCALE_GRID_EN is defined.
// ---------------------------------------------------------------------------
interface scale_window_ctrl_if;
    import scale_window_ctrl_pkg::*;

    logic [CX_W-1:0]        cx;
    logic [CY_W-1:0]        cy;
    logic [CX_W-1:0]        frameWidth;
    logic [CY_W-1:0]        frameHeight;
    logic                   newFrameIn;
    logic                   sameLine;
    logic                   setStart;
    logic [CX_W-1:0]        setStartX;
    logic [CY_W-1:0]        setStartY;
    logic                   drawActive;
    logic [SRC_IDX_W-1:0]   srcPxl;
    logic [SRC_IDX_W-1:0]   srcLine;
    logic [SCALE_CNT_W-1:0] xsel;
    logic [SCALE_CNT_W-1:0] ysel;
    logic                   nextLine;
    logic                   cacheUpdate;
    logic                   locked;
`ifdef SCALE_GRID_EN
    logic                   gridAct;
`endif

    modport master (
        output cx, cy, frameWidth, frameHeight, newFrameIn, sameLine,
        input  setStart, setStartX, setStartY, drawActive, srcPxl, srcLine,
        input  xsel, ysel, nextLine, cacheUpdate, locked
`ifdef SCALE_GRID_EN
        , input gridAct
`endif
    );

    modport slave (
        input  cx, cy, frameWidth, frameHeight, newFrameIn, sameLine,
        output setStart, setStartX, setStartY, drawActive, srcPxl, srcLine,
        output xsel, ysel, nextLine, cacheUpdate, locked
`ifdef SCALE_GRID_EN
        , output gridAct
`endif
    );

endinterface

// File: rtl/scale_window_ctrl_axis_scale_cnt.sv
// ---------------------------------------------------------------------------
// axis_scale_cnt
// One scaled axis: a sub-counter running 0..SCALE-1 and a source index that
// steps each time the sub-counter wraps, saturating at LEN-1.
//   clk, rst : clock and synchronous active-high reset
//   advance  : step the sub-counter this cycle
//   clear    : force sub and idx to 0 (wins over advance)
//   sub      : sub-pixel / sub-line select (registered)
//   idx      : source pixel / line index (registered, saturating)
// With SCALE == 1 the sub-counter stays 0 and idx steps on every advance.
// ---------------------------------------------------------------------------
module axis_scale_cnt
    import scale_window_ctrl_pkg::*;
#(
    parameter int SCALE = 4,
    parameter int LEN   = 240
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   advance,
    input  logic                   clear,
    output logic [SCALE_CNT_W-1:0] sub,
    output logic [SRC_IDX_W-1:0]   idx
);

    if ((SCALE < 1) || (SCALE > 8)) begin : g_bad_scale
        $error("axis_scale_cnt: SCALE must be 1..8");
    end
    if ((LEN < 1) || (LEN > 256)) begin : g_bad_len
        $error("axis_scale_cnt: LEN must be 1..256");
    end

    localparam logic [SCALE_CNT_W-1:0] SUB_LAST = SCALE_CNT_W'(SCALE - 1);
    localparam logic [SRC_IDX_W-1:0]   IDX_LAST = SRC_IDX_W'(LEN - 1);

    logic [SCALE_CNT_W-1:0] sub_r, sub_next_s;
    logic [SRC_IDX_W-1:0]   idx_r, idx_next_s;

    // Next-state of the sub-counter and saturating index.
    always_comb begin
        sub_next_s = sub_r;
        idx_next_s = idx_r;
        if (clear) begin
            sub_next_s = {SCALE_CNT_W{1'b0}};
            idx_next_s = {SRC_IDX_W{1'b0}};
        end else if (advance) begin
            if (sub_r == SUB_LAST) begin
                sub_next_s = {SCALE_CNT_W{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_next_s = idx_r;
                end else begin
                    idx_next_s = idx_r + {{(SRC_IDX_W-1){1'b0}}, 1'b1};
                end
            end else begin
                sub_next_s = sub_r + {{(SCALE_CNT_W-1){1'b0}}, 1'b1};
                idx_next_s = idx_r;
            end
        end else begin
            sub_next_s = sub_r;
            idx_next_s = idx_r;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_r <= {SCALE_CNT_W{1'b0}};
            idx_r <= {SRC_IDX_W{1'b0}};
        end else begin
            sub_r <= sub_next_s;
            idx_r <= idx_next_s;
        end
    end

    assign sub = sub_r;
    assign idx = idx_r;

endmodule

// File: rtl/scale_window_ctrl.sv
// ---------------------------------------------------------------------------
// scale_window_ctrl
// Timing/addressing engine between the HDMI core and the GBA line cache.
// Centres a SCALE_X x SCALE_Y scaled SRC_W x SRC_H window inside the frame,
// produces source pixel/line indices with per-axis sub-pixel selects, the
// per-line cache request pulses and the frame-lock handshake that presets the
// HDMI counters when a new GBA frame starts.
// Ports:
//   pxlClk : pixel clock (sole clock)
//   rst    : synchronous active-high reset
//   bus    : scale_window_ctrl_if.slave
//            in : cx, cy, frameWidth, frameHeight, newFrameIn, sameLine
//            out: setStart, setStartX, setStartY, drawActive, srcPxl, srcLine,
//                 xsel, ysel, nextLine, cacheUpdate, locked, [gridAct]
// Build option: define SCALE_GRID_EN to add the gridAct output, high on the
// first sub-pixel column or sub-line row of each scaled pixel, aligned with
// xsel.
// ---------------------------------------------------------------------------
module scale_window_ctrl
    import scale_window_ctrl_pkg::*;
#(
    parameter int FRAME_W       = 1280,
    parameter int FRAME_H       = 720,
    parameter int SRC_W         = 240,
    parameter int SRC_H         = 160,
    parameter int SCALE_X       = 4,
    parameter int SCALE_Y       = 4,
    parameter int LINE_REQ_LEAD = 8,
    parameter int LOCK_LEAD     = 2,
    parameter int XSEL_DLY      = 2
) (
    input  logic               pxlClk,
    input  logic               rst,
    scale_window_ctrl_if.slave bus
);

    if (FRAME_W < SCALE_X * SRC_W) begin : g_bad_width
        $error("scale_window_ctrl: scaled width exceeds FRAME_W");
    end
    if (FRAME_H < SCALE_Y * SRC_H) begin : g_bad_height
        $error("scale_window_ctrl: scaled height exceeds FRAME_H");
    end
    if (window_start(FRAME_H, SCALE_Y, SRC_H) < LOCK_LEAD) begin : g_bad_lead
        $error("scale_window_ctrl: LOCK_LEAD larger than vertical window offset");
    end
    if (XSEL_DLY < 0) begin : g_bad_dly
        $error("scale_window_ctrl: XSEL_DLY must be >= 0");
    end

    localparam int X_START_I = window_start(FRAME_W, SCALE_X, SRC_W);
    localparam int Y_START_I = window_start(FRAME_H, SCALE_Y, SRC_H);

    localparam logic [CX_W-1:0]        X_START     = CX_W'(X_START_I);
    localparam logic [CX_W-1:0]        X_END       = CX_W'(X_START_I + SCALE_X * SRC_W);
    localparam logic [CY_W-1:0]        Y_START     = CY_W'(Y_START_I);
    localparam logic [CY_W-1:0]        Y_END       = CY_W'(Y_START_I + SCALE_Y * SRC_H);
    localparam logic [CY_W-1:0]        SET_START_Y = CY_W'(Y_START_I - LOCK_LEAD);
    localparam logic [CX_W-1:0]        REQ_OFFSET  = CX_W'(LINE_REQ_LEAD);
    localparam logic [SCALE_CNT_W-1:0] Y_SUB_LAST  = SCALE_CNT_W'(SCALE_Y - 1);

    // ---------------- position decode ----------------
    logic in_window_s;
    logic line_end_s;
    logic req_col_s;
    logic frame_end_s;
    logic in_ylines_s;

    assign in_window_s = (bus.cx >= X_START) && (bus.cx < X_END) &&
                         (bus.cy >= Y_START) && (bus.cy < Y_END);
    assign line_end_s  = (bus.cx == (bus.frameWidth - 12'd1));
    assign req_col_s   = (bus.cx == (bus.frameWidth - REQ_OFFSET));
    assign frame_end_s = line_end_s && (bus.cy == (bus.frameHeight - 11'd1));
    // Deliberately unbounded above: ysel keeps cycling and srcLine holds
    // saturated below the window until the frame-end clear.
    assign in_ylines_s = (bus.cy >= Y_START);

    // ---------------- frame-lock FSM ----------------
    lock_state_t state_r, state_next_s;
    logic        nf_d_r;
    logic [CY_W-1:0] cy_d_r;
    logic        nf_rise_s;
    logic        cy_moved_s;

    assign nf_rise_s  = bus.newFrameIn && !nf_d_r;
    assign cy_moved_s = (bus.cy != cy_d_r);

    // Edge/change detectors; the edge history resets high so a level already
    // high at reset release is not mistaken for a new frame.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            nf_d_r <= 1'b1;
            cy_d_r <= {CY_W{1'b0}};
        end else begin
            nf_d_r <= bus.newFrameIn;
            cy_d_r <= bus.cy;
        end
    end

    // FSM state register.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            state_r <= FREE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: REQ waits for the HDMI core to apply the preset, which
    // shows up as cy moving; further frame edges during REQ are ignored.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FREE: begin
                if (nf_rise_s) state_next_s = REQ;
                else           state_next_s = FREE;
            end
            REQ: begin
                if (cy_moved_s) state_next_s = LOCKED;
                else            state_next_s = REQ;
            end
            LOCKED: begin
                if (nf_rise_s) state_next_s = REQ;
                else           state_next_s = LOCKED;
            end
            default: state_next_s = FREE;
        endcase
    end

    // ---------------- axis counters ----------------
    logic [SCALE_CNT_W-1:0] x_sub_s, y_sub_s;
    logic [SRC_IDX_W-1:0]   src_pxl_s, src_line_s;
    logic                   draw_active_r;
    logic                   x_adv_s, x_clr_s, y_adv_s, y_clr_s;

    // X steps only once drawActive is already high, so sub/srcPxl line up
    // with drawActive; leaving the window clears on the same edge that drops
    // drawActive.
    assign x_adv_s = in_window_s && draw_active_r;
    assign x_clr_s = !in_window_s;
    assign y_adv_s = line_end_s && in_ylines_s;
    assign y_clr_s = frame_end_s || (state_r == REQ);

    axis_scale_cnt #(.SCALE(SCALE_X), .LEN(SRC_W)) u_x_cnt (
        .clk     (pxlClk),
        .rst     (rst),
        .advance (x_adv_s),
        .clear   (x_clr_s),
        .sub     (x_sub_s),
        .idx     (src_pxl_s)
    );

    axis_scale_cnt #(.SCALE(SCALE_Y), .LEN(SRC_H)) u_y_cnt (
        .clk     (pxlClk),
        .rst     (rst),
        .advance (y_adv_s),
        .clear   (y_clr_s),
        .sub     (y_sub_s),
        .idx     (src_line_s)
    );

    // ---------------- registered outputs ----------------
    logic                   set_start_r;
    logic [CY_W-1:0]        set_start_y_r;
    logic                   next_line_r;
    logic                   cache_update_r;
    logic                   locked_r;

    // Window flag, cache pulses and handshake outputs.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            draw_active_r  <= 1'b0;
            set_start_r    <= 1'b0;
            set_start_y_r  <= {CY_W{1'b0}};
            next_line_r    <= 1'b0;
            cache_update_r <= 1'b0;
            locked_r       <= 1'b0;
        end else begin
            draw_active_r  <= in_window_s;
            set_start_r    <= (state_next_s == REQ);
            set_start_y_r  <= (state_next_s == REQ) ? SET_START_Y : {CY_W{1'b0}};
            cache_update_r <= req_col_s;
            next_line_r    <= req_col_s && (y_sub_s == Y_SUB_LAST) && in_ylines_s &&
                              !bus.sameLine && (state_r != REQ);
            locked_r       <= (state_next_s == LOCKED);
        end
    end

    // ---------------- xsel (and grid) alignment pipe ----------------
`ifdef SCALE_GRID_EN
    localparam int PIPE_W = SCALE_CNT_W + 1;
`else
    localparam int PIPE_W = SCALE_CNT_W;
`endif

    logic [PIPE_W-1:0] pipe_in_s;
    logic [PIPE_W-1:0] pipe_out_s;

`ifdef SCALE_GRID_EN
    logic grid_raw_s;
    assign grid_raw_s = ((x_sub_s == {SCALE_CNT_W{1'b0}}) || (y_sub_s == {SCALE_CNT_W{1'b0}})) &&
                        draw_active_r;
    assign pipe_in_s  = {grid_raw_s, x_sub_s};
`else
    assign pipe_in_s  = x_sub_s;
`endif

    if (XSEL_DLY == 0) begin : g_no_dly
        assign pipe_out_s = pipe_in_s;
    end else begin : g_dly
        logic [PIPE_W-1:0] pipe_r [XSEL_DLY];

        // Shift register delaying xsel to line up with cache read data.
        always_ff @(posedge pxlClk) begin
            if (rst) begin
                for (int i = 0; i < XSEL_DLY; i++) begin
                    pipe_r[i] <= {PIPE_W{1'b0}};
                end
            end else begin
                pipe_r[0] <= pipe_in_s;
                for (int i = 1; i < XSEL_DLY; i++) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end
        end

        assign pipe_out_s = pipe_r[XSEL_DLY-1];
    end

    // ---------------- port drive ----------------
    assign bus.setStart    = set_start_r;
    assign bus.setStartX   = {CX_W{1'b0}};
    assign bus.setStartY   = set_start_y_r;
    assign bus.drawActive  = draw_active_r;
    assign bus.srcPxl      = src_pxl_s;
    assign bus.srcLine     = src_line_s;
    assign bus.xsel        = pipe_out_s[SCALE_CNT_W-1:0];
    assign bus.ysel        = y_sub_s;
    assign bus.nextLine    = next_line_r;
    assign bus.cacheUpdate = cache_update_r;
    assign bus.locked      = locked_r;
`ifdef SCALE_GRID_EN
    assign bus.gridAct     = pipe_out_s[PIPE_W-1];
`endif

endmodule
